alu_op_sequencer: RTL and testbench

//  Command front-end for alu_16_bit. Accepts one (op, a, b) command per valid/ready handshake.

---
 rtl/alu_op_sequencer.sv | 125 ++++++++++++
 tb/tb_alu_op_sequencer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Command front-end for a pipelined 16-bit ALU: accepts one command, waits out the ALU latency,
// captures result and flags, and hands them back over a valid/ready result port.
module alu_op_sequencer #(
   parameter int unsigned Width      = 16,
   parameter int unsigned Opw        = 4,
   parameter int unsigned AluLatency = 1,
   parameter int unsigned CntW       = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             cmd_valid_i,
   output logic             cmd_ready_o,
   input  logic [Opw-1:0]   cmd_op_i,
   input  logic [Width-1:0] cmd_a_i,
   input  logic [Width-1:0] cmd_b_i,
   input  logic             cmd_use_acc_i,
   output logic [Width-1:0] alu_a_o,
   output logic [Width-1:0] alu_b_o,
   output logic [Opw-1:0]   alu_op_o,
   input  logic [Width-1:0] alu_q_i,
   input  logic             alu_cb_i,
   input  logic             alu_zero_i,
   input  logic             alu_sign_i,
   input  logic             alu_cf_i,
   input  logic             alu_par_i,
   output logic             res_valid_o,
   input  logic             res_ready_i,
   output logic [Width-1:0] res_q_o,
   output logic [4:0]       res_flags_o,
   output logic             busy_o,
   output logic [CntW-1:0]  op_count_o
);

   typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

   localparam logic [3:0] LatInit = 4'(AluLatency);

   state_e           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             cmd_ready_q, cmd_ready_d;
   logic [Width-1:0] alu_a_q, alu_a_d;
   logic [Width-1:0] alu_b_q, alu_b_d;
   logic [Opw-1:0]   alu_op_q, alu_op_d;
   logic [Width-1:0] res_q_q, res_q_d;
   logic [4:0]       res_flags_q, res_flags_d;
   logic [Width-1:0] acc_q, acc_d;
   logic [CntW-1:0]  op_count_q, op_count_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         cmd_ready_q <= 1'b0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_op_q    <= '0;
         res_q_q     <= '0;
         res_flags_q <= '0;
         acc_q       <= '0;
         op_count_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cmd_ready_q <= cmd_ready_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_op_q    <= alu_op_d;
         res_q_q     <= res_q_d;
         res_flags_q <= res_flags_d;
         acc_q       <= acc_d;
         op_count_q  <= op_count_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_op_d    = alu_op_q;
      res_q_d     = res_q_q;
      res_flags_d = res_flags_q;
      acc_d       = acc_q;
      op_count_d  = op_count_q;
      case (state_q)
         StIdle: begin
            if (cmd_valid_i && cmd_ready_q) begin
               alu_op_d = cmd_op_i;
               alu_b_d  = cmd_b_i;
               alu_a_d  = cmd_use_acc_i ? acc_q : cmd_a_i;
               cnt_d    = LatInit;
               state_d  = StWait;
            end
         end
         StWait: begin
            // Capture on the edge after the counter has reached zero.
            if (cnt_q == 4'd0) begin
               res_q_d     = alu_q_i;
               res_flags_d = {alu_par_i, alu_cf_i, alu_sign_i, alu_zero_i, alu_cb_i};
               acc_d       = alu_q_i;
               op_count_d  = op_count_q + CntW'(1);
               state_d     = StDone;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StDone: begin
            if (res_ready_i) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      cmd_ready_d = (state_d == StIdle);
   end

   assign cmd_ready_o = cmd_ready_q;
   assign alu_a_o     = alu_a_q;
   assign alu_b_o     = alu_b_q;
   assign alu_op_o    = alu_op_q;
   assign res_valid_o = (state_q == StDone);
   assign res_q_o     = res_q_q;
   assign res_flags_o = res_flags_q;
   assign busy_o      = (state_q != StIdle);
   assign op_count_o  = op_count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a registered 1-cycle add/sub ALU model.
// A second instance with a 3-bit counter exercises op_count wrap-around.
module tb_alu_op_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid, cmd_ready, cmd_use_acc, res_valid, res_ready, busy;
   logic [3:0]  cmd_op, alu_op;
   logic [15:0] cmd_a, cmd_b, alu_a, alu_b, alu_q, res_q, op_count;
   logic        alu_cb, alu_zero, alu_sign, alu_cf, alu_par;
   logic [4:0]  res_flags;

   logic        s_cmd_ready, s_res_valid, s_busy;
   logic [3:0]  s_alu_op;
   logic [15:0] s_alu_a, s_alu_b, s_res_q;
   logic [4:0]  s_res_flags;
   logic [2:0]  s_op_count;

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   alu_op_sequencer u_dut (
      .clk_i(clk), .rst_ni(rst_n), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
      .cmd_op_i(cmd_op), .cmd_a_i(cmd_a), .cmd_b_i(cmd_b), .cmd_use_acc_i(cmd_use_acc),
      .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_op_o(alu_op), .alu_q_i(alu_q),
      .alu_cb_i(alu_cb), .alu_zero_i(alu_zero), .alu_sign_i(alu_sign), .alu_cf_i(alu_cf),
      .alu_par_i(alu_par), .res_valid_o(res_valid), .res_ready_i(res_ready), .res_q_o(res_q),
      .res_flags_o(res_flags), .busy_o(busy), .op_count_o(op_count)
   );

   alu_op_sequencer #(.CntW(3)) u_dut_small (
      .clk_i(clk), .rst_ni(rst_n), .cmd_valid_i(cmd_valid), .cmd_ready_o(s_cmd_ready),
      .cmd_op_i(cmd_op), .cmd_a_i(cmd_a), .cmd_b_i(cmd_b), .cmd_use_acc_i(cmd_use_acc),
      .alu_a_o(s_alu_a), .alu_b_o(s_alu_b), .alu_op_o(s_alu_op), .alu_q_i(alu_q),
      .alu_cb_i(alu_cb), .alu_zero_i(alu_zero), .alu_sign_i(alu_sign), .alu_cf_i(alu_cf),
      .alu_par_i(alu_par), .res_valid_o(s_res_valid), .res_ready_i(res_ready),
      .res_q_o(s_res_q), .res_flags_o(s_res_flags), .busy_o(s_busy), .op_count_o(s_op_count)
   );

   // ALU model: op 1 = a+b, op 2 = a-b; cb = carry/borrow, cf = signed overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      logic [16:0] r;
      logic        ov;
      if (!rst_n) begin
         alu_q <= '0; alu_cb <= 1'b0; alu_zero <= 1'b0;
         alu_sign <= 1'b0; alu_cf <= 1'b0; alu_par <= 1'b0;
      end else begin
         r  = '0;
         ov = 1'b0;
         if (alu_op == 4'd1) begin
            r  = {1'b0, alu_a} + {1'b0, alu_b};
            ov = (alu_a[15] == alu_b[15]) && (r[15] != alu_a[15]);
         end else if (alu_op == 4'd2) begin
            r  = {1'b0, alu_a} - {1'b0, alu_b};
            ov = (alu_a[15] != alu_b[15]) && (r[15] != alu_a[15]);
         end
         alu_q    <= r[15:0];
         alu_cb   <= r[16];
         alu_zero <= (r[15:0] == 16'h0);
         alu_sign <= r[15];
         alu_cf   <= ov;
         alu_par  <= ^r[15:0];
      end
   end

   task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic acc);
      int n;
      @(negedge clk);
      cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = acc; cmd_valid = 1'b1;
      n = 0;
      while (!cmd_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) begin
         checks++;
         $display("FAIL accept_timeout: cmd_ready=%b required 1", cmd_ready);
      end
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   // Issues one command with res_ready=1; returns alu_a seen after accept plus the result.
   task automatic do_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic acc, output logic [15:0] a_seen, output logic [15:0] q,
                        output logic [4:0] fl);
      int n;
      send(op, a, b, acc);
      a_seen = alu_a;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!res_valid && n < 10);
      if (!res_valid) begin
         checks++;
         $display("FAIL result_timeout: res_valid=%b required 1", res_valid);
      end
      q  = res_q;
      fl = res_flags;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
      cmd_use_acc = 1'b0; res_ready = 1'b1;
      #12;
      checks++; if (cmd_ready !== 1'b0) $display("FAIL rst_cmd_ready: got %b want 0", cmd_ready);
      else passes++;
      checks++; if (res_valid !== 1'b0) $display("FAIL rst_res_valid: got %b want 0", res_valid);
      else passes++;
      checks++; if (op_count !== 16'h0) $display("FAIL rst_op_count: got %h want 0", op_count);
      else passes++;
      checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy);
      else passes++;
      #8 rst_n = 1'b1;
      #2;
      checks++; if (cmd_ready !== 1'b0) $display("FAIL pre_edge_ready: got %b want 0", cmd_ready);
      else passes++;
      @(negedge clk);
      checks++; if (cmd_ready !== 1'b1) $display("FAIL post_edge_ready: got %b want 1", cmd_ready);
      else passes++;
   endtask

   task automatic test_basic();
      send(4'd1, 16'd10, 16'd5, 1'b0);
      checks++; if (alu_a !== 16'd10) $display("FAIL basic_alu_a: got %h want 000a", alu_a);
      else passes++;
      checks++; if (alu_b !== 16'd5) $display("FAIL basic_alu_b: got %h want 0005", alu_b);
      else passes++;
      checks++; if (alu_op !== 4'd1) $display("FAIL basic_alu_op: got %h want 1", alu_op);
      else passes++;
      checks++; if (busy !== 1'b1 || cmd_ready !== 1'b0)
         $display("FAIL basic_busy: got busy=%b ready=%b want 1/0", busy, cmd_ready);
      else passes++;
      @(negedge clk);
      checks++; if (res_valid !== 1'b0) $display("FAIL basic_early0: got %b want 0", res_valid);
      else passes++;
      @(negedge clk);
      checks++; if (res_valid !== 1'b0) $display("FAIL basic_early1: got %b want 0", res_valid);
      else passes++;
      @(negedge clk);
      checks++; if (res_valid !== 1'b1) $display("FAIL basic_valid: got %b want 1", res_valid);
      else passes++;
      checks++; if (res_q !== 16'd15) $display("FAIL basic_q: got %h want 000f", res_q);
      else passes++;
      checks++; if (res_flags !== 5'b00000) $display("FAIL basic_flags: got %b want 00000", res_flags);
      else passes++;
      checks++; if (op_count !== 16'd1) $display("FAIL basic_count: got %h want 1", op_count);
      else passes++;
      @(negedge clk);
      checks++; if (res_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0)
         $display("FAIL basic_after: got valid=%b ready=%b busy=%b want 0/1/0",
                  res_valid, cmd_ready, busy);
      else passes++;
   endtask

   task automatic test_flags();
      logic [15:0] as, q;
      logic [4:0]  fl;
      do_op(4'd2, 16'd5, 16'd5, 1'b0, as, q, fl);
      checks++; if (q !== 16'h0 || fl !== 5'b00010)
         $display("FAIL sub_zero: got q=%h fl=%b want 0000/00010", q, fl);
      else passes++;
      do_op(4'd2, 16'd3, 16'd5, 1'b0, as, q, fl);
      checks++; if (q !== 16'hFFFE || fl !== 5'b10101)
         $display("FAIL sub_borrow: got q=%h fl=%b want fffe/10101", q, fl);
      else passes++;
      do_op(4'd1, 16'h7FFF, 16'h0001, 1'b0, as, q, fl);
      checks++; if (q !== 16'h8000 || fl !== 5'b11100)
         $display("FAIL add_ovf: got q=%h fl=%b want 8000/11100", q, fl);
      else passes++;
   endtask

   task automatic test_chain();
      logic [15:0] as, q;
      logic [4:0]  fl;
      do_op(4'd1, 16'h0001, 16'h0002, 1'b0, as, q, fl);
      checks++; if (q !== 16'h3) $display("FAIL chain_first: got %h want 0003", q);
      else passes++;
      do_op(4'd1, 16'h7777, 16'h0004, 1'b1, as, q, fl);
      checks++; if (as !== 16'h3) $display("FAIL chain_alu_a: got %h want 0003", as);
      else passes++;
      checks++; if (q !== 16'h7 || fl !== 5'b10000)
         $display("FAIL chain_q: got q=%h fl=%b want 0007/10000", q, fl);
      else passes++;
   endtask

   task automatic test_back_to_back_stall();
      int n;
      res_ready = 1'b0;
      send(4'd1, 16'h0100, 16'h0020, 1'b0);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!res_valid && n < 10);
      for (int i = 0; i < 5; i++) begin
         cmd_valid = 1'b1; cmd_op = 4'd2; cmd_a = 16'hDEAD; cmd_b = 16'hBEEF;
         @(negedge clk);
         cmd_valid = 1'b0;
         checks++; if (res_valid !== 1'b1 || res_q !== 16'h0120 || cmd_ready !== 1'b0)
            $display("FAIL stall_hold%0d: got valid=%b q=%h ready=%b want 1/0120/0",
                     i, res_valid, res_q, cmd_ready);
         else passes++;
      end
      checks++; if (alu_a !== 16'h0100 || alu_op !== 4'd1)
         $display("FAIL stall_ignore: got a=%h op=%h want 0100/1", alu_a, alu_op);
      else passes++;
      res_ready = 1'b1;
      @(negedge clk);
      checks++; if (res_valid !== 1'b0 || cmd_ready !== 1'b1)
         $display("FAIL stall_release: got valid=%b ready=%b want 0/1", res_valid, cmd_ready);
      else passes++;
   endtask

   task automatic test_reset_in_wait();
      logic [15:0] as, q;
      logic [4:0]  fl;
      int          seen;
      send(4'd1, 16'h0011, 16'h0022, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      checks++; if ({alu_a, alu_b, alu_op, res_q, res_flags} !== '0)
         $display("FAIL rst_wait_data: got a=%h b=%h op=%h q=%h fl=%b want all 0",
                  alu_a, alu_b, alu_op, res_q, res_flags);
      else passes++;
      checks++; if ({busy, cmd_ready, res_valid} !== 3'b000 || op_count !== 16'h0)
         $display("FAIL rst_wait_ctl: got busy=%b ready=%b valid=%b cnt=%h want 0",
                  busy, cmd_ready, res_valid, op_count);
      else passes++;
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (res_valid) seen++;
      end
      checks++; if (seen !== 0 || op_count !== 16'h0)
         $display("FAIL rst_wait_noresult: got valid_cycles=%0d cnt=%h want 0/0", seen, op_count);
      else passes++;
      do_op(4'd1, 16'hAAAA, 16'h0005, 1'b1, as, q, fl);
      checks++; if (as !== 16'h0 || q !== 16'h5)
         $display("FAIL rst_acc: got a=%h q=%h want 0000/0005", as, q);
      else passes++;
   endtask

   task automatic test_count_wrap();
      logic [15:0] as, q;
      logic [4:0]  fl;
      for (int i = 0; i < 6; i++) do_op(4'd1, 16'(i), 16'h0, 1'b0, as, q, fl);
      checks++; if (s_op_count !== 3'd7) $display("FAIL wrap_pre: got %0d want 7", s_op_count);
      else passes++;
      do_op(4'd1, 16'h0, 16'h0, 1'b0, as, q, fl);
      checks++; if (s_op_count !== 3'd0) $display("FAIL wrap_zero: got %0d want 0", s_op_count);
      else passes++;
      checks++; if (op_count !== 16'd8) $display("FAIL wrap_main: got %0d want 8", op_count);
      else passes++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_flags();
      test_chain();
      test_back_to_back_stall();
      test_reset_in_wait();
      test_count_wrap();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
